// File: rtl/l1a_lct_matcher_if.sv
`default_nettype none
// ============================================================================
//  Module   : l1a_lct_matcher_if
//  Purpose  : Bundles the stimulus, configuration and result signals of the
//             L1A/LCT matcher so the matcher and its environment connect
//             through a single port.
//  Ports    : i_lct / i_l1a          - live LCT strobes (bit 0 = ALCT) and L1A
//             i_cal_mode             - selects the calibration sources below
//             i_cal_lct / i_cal_l1a  - calibration LCT pattern and L1A
//             i_kill_mask            - bit k-1 forces channel k LCT low
//             i_latency / i_window   - LCT-to-L1A latency L, half window W
//             i_push_dly             - push delay P after a match
//             o_l1a_out              - L1A aligned with o_l1a_match
//             o_l1a_match / o_push   - per-channel match and delayed push
//             o_l1a_nomatch          - L1A with no channel matched
//             o_lcterr               - ALCT/CFEB inconsistency flag
//             o_l1a_cnt              - 24-bit L1A event counter
//             Modport slave is the matcher; modport master is its driver.
//  Revision : 1.0 - initial release
// ============================================================================
interface l1a_lct_matcher_if #(
  parameter int NCH   = 7,
  parameter int LAT_W = 7,
  parameter int PD_W  = 5
);
  logic [NCH:0]   i_lct;
  logic           i_l1a;
  logic           i_cal_mode;
  logic [NCH:0]   i_cal_lct;
  logic           i_cal_l1a;
  logic [NCH-1:0] i_kill_mask;
  logic [LAT_W-1:0] i_latency;
  logic [2:0]     i_window;
  logic [PD_W-1:0] i_push_dly;

  logic           o_l1a_out;
  logic [NCH-1:0] o_l1a_match;
  logic [NCH-1:0] o_push;
  logic           o_l1a_nomatch;
  logic           o_lcterr;
  logic [23:0]    o_l1a_cnt;

  modport slave (
    input  i_lct, i_l1a, i_cal_mode, i_cal_lct, i_cal_l1a,
           i_kill_mask, i_latency, i_window, i_push_dly,
    output o_l1a_out, o_l1a_match, o_push, o_l1a_nomatch, o_lcterr, o_l1a_cnt
  );

  modport master (
    output i_lct, i_l1a, i_cal_mode, i_cal_lct, i_cal_l1a,
           i_kill_mask, i_latency, i_window, i_push_dly,
    input  o_l1a_out, o_l1a_match, o_push, o_l1a_nomatch, o_lcterr, o_l1a_cnt
  );
endinterface
`default_nettype wire

// File: rtl/l1a_lct_matcher.sv
`default_nettype none
// ============================================================================
//  Module   : l1a_lct_matcher
//  Purpose  : Matches L1 accepts against per-channel LCT history. Channel k
//             matches an L1A at cycle t when its (un-killed) LCT was seen at
//             a cycle s with max(1, L-W) <= t-s <= L+W. Matches are reported
//             two cycles after the L1A and re-issued as PUSH pulses P cycles
//             later through a fully pipelined delay line.
//  Ports    : clk  - sole clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - l1a_lct_matcher_if.slave (inputs i_*, outputs o_*)
//  Options  : L1A_MATCH_TMR_EN - when defined, the LCT history, the window
//             stretcher and the push delay line exist in three copies that
//             are combined by a bitwise 2-of-3 vote; cycle behaviour is the
//             same as the single-copy build.
//  Revision : 1.0 - initial release
// ============================================================================
module l1a_lct_matcher #(
  parameter int NCH   = 7,
  parameter int LAT_W = 7,
  parameter int PD_W  = 5
) (
  input  logic clk,
  input  logic rst,
  l1a_lct_matcher_if.slave bus
);

  // History depth covers delays 1 .. 2**LAT_W; delay 0 never matches.
  localparam int c_DEPTH = 2**LAT_W;
  // Push line positions 1 .. 2**PD_W-1; position 0 is the output register.
  localparam int c_PDEP  = 2**PD_W;
  // Wide enough for L+W without overflow.
  localparam int c_DW    = LAT_W + 4;

`ifdef L1A_MATCH_TMR_EN
  localparam int c_NCOPY = 3;
`else
  localparam int c_NCOPY = 1;
`endif

  // --------------------------------------------------------------------------
  // Stage 1: source select, kill mask, input registration
  // --------------------------------------------------------------------------
  logic [NCH:0] w_sel_lct;
  logic [NCH:0] w_kill_lct;
  logic         w_sel_l1a;

  always_comb begin
    w_sel_lct  = bus.i_cal_mode ? bus.i_cal_lct : bus.i_lct;
    w_sel_l1a  = bus.i_cal_mode ? bus.i_cal_l1a : bus.i_l1a;
    // ALCT bit 0 is never killed.
    w_kill_lct = w_sel_lct & {~bus.i_kill_mask, 1'b1};
  end

  logic [NCH:0] r_lct;
  logic         r_l1a;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lct <= '0;
      r_l1a <= 1'b0;
    end else begin
      r_lct <= w_kill_lct;
      r_l1a <= w_sel_l1a;
    end
  end

  // --------------------------------------------------------------------------
  // Window bounds and per-tap enables. Tap j of the history holds the LCT
  // seen j+1 cycles before the L1A currently in r_l1a.
  // --------------------------------------------------------------------------
  logic [c_DW-1:0]    w_lat;
  logic [c_DW-1:0]    w_win;
  logic [c_DW-1:0]    w_lo;
  logic [c_DW-1:0]    w_hi;
  logic [c_DEPTH-1:0] w_tap;

  always_comb begin
    w_lat = c_DW'(bus.i_latency);
    w_win = c_DW'(bus.i_window);
    // Lower bound clamps to 1 so a same-cycle LCT can never match.
    w_lo  = (w_lat < (w_win + c_DW'(1))) ? c_DW'(1) : (w_lat - w_win);
    w_hi  = w_lat + w_win;
    w_tap = '0;
    for (int j = 0; j < c_DEPTH; j++) begin
      w_tap[j] = (c_DW'(j + 1) >= w_lo) && (c_DW'(j + 1) <= w_hi);
    end
  end

  // --------------------------------------------------------------------------
  // LCT history (channels 1..NCH only). Each copy shifts from the voted
  // previous tap, so a corrupted copy is repaired as it shifts.
  // --------------------------------------------------------------------------
  (* keep = "true" *) logic [NCH-1:0] r_hist [c_NCOPY][c_DEPTH];
  logic [NCH-1:0] w_hist_v [c_DEPTH-1];

  always_ff @(posedge clk) begin
    for (int c = 0; c < c_NCOPY; c++) begin
      if (rst) begin
        for (int j = 0; j < c_DEPTH; j++) begin
          r_hist[c][j] <= '0;
        end
      end else begin
        r_hist[c][0] <= r_lct[NCH:1];
        for (int j = 1; j < c_DEPTH; j++) begin
          r_hist[c][j] <= w_hist_v[j-1];
        end
      end
    end
  end

  // Window stretcher: OR of all history taps inside [lo, hi], per copy.
  (* keep = "true" *) logic [NCH-1:0] w_hit [c_NCOPY];
  logic [NCH-1:0] w_hit_v;

  always_comb begin
    for (int c = 0; c < c_NCOPY; c++) begin
      w_hit[c] = '0;
      for (int j = 0; j < c_DEPTH; j++) begin
        w_hit[c] = w_hit[c] | (r_hist[c][j] & {NCH{w_tap[j]}});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Push delay line. A match is loaded at position P and walks toward the
  // output; the load position is chosen when the match occurs, so a later
  // change of P never retimes pushes already in flight.
  // --------------------------------------------------------------------------
  (* keep = "true" *) logic [NCH-1:0] r_pl [c_NCOPY][c_PDEP-1];
  logic [NCH-1:0] w_pl_v [c_PDEP-1];
  logic [NCH-1:0] w_match;

  assign w_match = r_l1a ? w_hit_v : '0;

  always_ff @(posedge clk) begin
    for (int c = 0; c < c_NCOPY; c++) begin
      if (rst) begin
        for (int i = 0; i < c_PDEP - 1; i++) begin
          r_pl[c][i] <= '0;
        end
      end else begin
        // r_pl[c][i] represents delay position i+1.
        for (int i = 0; i < c_PDEP - 2; i++) begin
          r_pl[c][i] <= ((bus.i_push_dly == PD_W'(i + 1)) ? w_match : '0)
                        | w_pl_v[i+1];
        end
        r_pl[c][c_PDEP-2] <= (bus.i_push_dly == PD_W'(c_PDEP - 1)) ? w_match : '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Voting (or pass-through in the single-copy build)
  // --------------------------------------------------------------------------
`ifdef L1A_MATCH_TMR_EN
  function automatic logic [NCH-1:0] f_vote(input logic [NCH-1:0] a,
                                            input logic [NCH-1:0] b,
                                            input logic [NCH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  for (genvar j = 0; j < c_DEPTH - 1; j++) begin : g_hist_vote
    assign w_hist_v[j] = f_vote(r_hist[0][j], r_hist[1][j], r_hist[2][j]);
  end

  for (genvar i = 0; i < c_PDEP - 1; i++) begin : g_pl_vote
    assign w_pl_v[i] = f_vote(r_pl[0][i], r_pl[1][i], r_pl[2][i]);
  end

  assign w_hit_v = f_vote(w_hit[0], w_hit[1], w_hit[2]);
`else
  for (genvar j = 0; j < c_DEPTH - 1; j++) begin : g_hist_pass
    assign w_hist_v[j] = r_hist[0][j];
  end

  for (genvar i = 0; i < c_PDEP - 1; i++) begin : g_pl_pass
    assign w_pl_v[i] = r_pl[0][i];
  end

  assign w_hit_v = w_hit[0];
`endif

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  logic           r_l1a_out;
  logic [NCH-1:0] r_match;
  logic           r_nomatch;
  logic [NCH-1:0] r_push;
  logic           r_lcterr;
  logic [23:0]    r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_l1a_out <= 1'b0;
      r_match   <= '0;
      r_nomatch <= 1'b0;
      r_push    <= '0;
      r_lcterr  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_l1a_out <= r_l1a;
      r_match   <= w_match;
      r_nomatch <= r_l1a & ~(|w_match);
      // P = 0 bypasses the line and pushes alongside the match itself.
      r_push    <= ((bus.i_push_dly == '0) ? w_match : '0) | w_pl_v[0];
      r_lcterr  <= r_lct[0] ^ (|r_lct[NCH:1]);
      // Counted every cycle (adding 0 when idle); wraps naturally at 2**24.
      r_cnt     <= r_cnt + 24'(r_l1a);
    end
  end

  assign bus.o_l1a_out     = r_l1a_out;
  assign bus.o_l1a_match   = r_match;
  assign bus.o_l1a_nomatch = r_nomatch;
  assign bus.o_push        = r_push;
  assign bus.o_lcterr      = r_lcterr;
  assign bus.o_l1a_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_l1a_lct_matcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l1a_lct_matcher
//  Purpose  : Directed self-checking bench for l1a_lct_matcher. Inputs are
//             driven on the falling edge so each value is sampled at the
//             following rising edge; outputs are compared on falling edges.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_l1a_lct_matcher;
  localparam int NCH   = 7;
  localparam int LAT_W = 7;
  localparam int PD_W  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1a_lct_matcher_if #(.NCH(NCH), .LAT_W(LAT_W), .PD_W(PD_W)) bus ();

  l1a_lct_matcher #(.NCH(NCH), .LAT_W(LAT_W), .PD_W(PD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_o(input string tag, input logic e_out, input logic [NCH-1:0] e_m,
                       input logic e_nm, input logic [NCH-1:0] e_p);
    chk({tag, ".l1a_out"}, 32'(bus.o_l1a_out), 32'(e_out));
    chk({tag, ".match"},   32'(bus.o_l1a_match), 32'(e_m));
    chk({tag, ".nomatch"}, 32'(bus.o_l1a_nomatch), 32'(e_nm));
    chk({tag, ".push"},    32'(bus.o_push), 32'(e_p));
  endtask

  // One falling edge; the cycle index is the rising edge that will sample
  // whatever is driven now.
  task automatic nx();
    @(negedge clk);
    cyc++;
  endtask

  task automatic go(input int c);
    while (cyc < c) nx();
  endtask

  task automatic idle_in();
    bus.i_lct      = '0;
    bus.i_l1a      = 1'b0;
    bus.i_cal_mode = 1'b0;
    bus.i_cal_lct  = '0;
    bus.i_cal_l1a  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    nx();
    nx();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    idle_in();
    bus.i_kill_mask = '0;
    bus.i_latency   = 7'd20;
    bus.i_window    = 3'd0;
    bus.i_push_dly  = 5'd0;

    // ---------------- reset state; inputs ignored during reset -------------
    rst = 1'b1;
    bus.i_lct = 8'hFF;
    bus.i_l1a = 1'b1;
    go(4);
    chk_o("rst", 1'b0, 7'h00, 1'b0, 7'h00);
    chk("rst.lcterr", 32'(bus.o_lcterr), 32'h0);
    chk("rst.cnt", 32'(bus.o_l1a_cnt), 32'h0);
    go(5);
    rst = 1'b0;
    idle_in();
    // LCT=FF was present at the last reset edge (4); L1A 20 cycles later
    go(24); bus.i_l1a = 1'b1;
    go(25); bus.i_l1a = 1'b0;
    go(26);
    chk_o("post_rst", 1'b1, 7'h00, 1'b1, 7'h00);
    chk("post_rst.cnt", 32'(bus.o_l1a_cnt), 32'h1);

    // ---------------- L=20 W=0 P=0 exact latency -----------------------------
    do_reset();
    s = cyc + 2;
    go(s);      bus.i_lct = 8'h04;
    go(s + 1);  bus.i_lct = 8'h00;
    go(s + 20); bus.i_l1a = 1'b1;
    go(s + 21); bus.i_l1a = 1'b0;
    chk_o("exact.t1", 1'b0, 7'h00, 1'b0, 7'h00);
    go(s + 22);
    chk_o("exact.t2", 1'b1, 7'h02, 1'b0, 7'h02);
    chk("exact.cnt", 32'(bus.o_l1a_cnt), 32'h1);
    go(s + 23);
    chk_o("exact.t3", 1'b0, 7'h00, 1'b0, 7'h00);

    // ---------------- L=20 W=0: one cycle late -> no match -------------------
    do_reset();
    s = cyc + 2;
    go(s);      bus.i_lct = 8'h04;
    go(s + 1);  bus.i_lct = 8'h00;
    go(s + 21); bus.i_l1a = 1'b1;
    go(s + 22); bus.i_l1a = 1'b0;
    go(s + 23);
    chk_o("late", 1'b1, 7'h00, 1'b1, 7'h00);

    // ---------------- L=20 W=2 window edges, back-to-back L1As ---------------
    bus.i_window = 3'd2;
    do_reset();
    s = cyc + 2;
    go(s);      bus.i_lct = 8'h02;
    go(s + 1);  bus.i_lct = 8'h00;
    go(s + 17); bus.i_l1a = 1'b1;
    go(s + 18); bus.i_l1a = 1'b1;
    go(s + 19); bus.i_l1a = 1'b0;
    chk_o("win.d17", 1'b1, 7'h00, 1'b1, 7'h00);
    go(s + 20);
    chk_o("win.d18", 1'b1, 7'h01, 1'b0, 7'h01);
    go(s + 21);
    chk_o("win.gap", 1'b0, 7'h00, 1'b0, 7'h00);
    go(s + 22); bus.i_l1a = 1'b1;
    go(s + 23); bus.i_l1a = 1'b1;
    go(s + 24); bus.i_l1a = 1'b0;
    chk_o("win.d22", 1'b1, 7'h01, 1'b0, 7'h01);
    go(s + 25);
    chk_o("win.d23", 1'b1, 7'h00, 1'b1, 7'h00);

    // ---------------- L=1 W=2: lower bound clamps to 1 -----------------------
    bus.i_latency = 7'd1;
    do_reset();
    s = cyc + 2;
    go(s);      bus.i_lct = 8'h02; bus.i_l1a = 1'b1;
    go(s + 1);  bus.i_lct = 8'h00; bus.i_l1a = 1'b1;
    go(s + 2);  bus.i_l1a = 1'b0;
    chk_o("clamp.d0", 1'b1, 7'h00, 1'b1, 7'h00);
    go(s + 3);
    chk_o("clamp.d1", 1'b1, 7'h01, 1'b0, 7'h01);

    // ---------------- kill mask and LCTERR -----------------------------------
    bus.i_latency   = 7'd5;
    bus.i_window    = 3'd0;
    bus.i_kill_mask = 7'h01;
    do_reset();
    s = cyc + 2;
    go(s);      bus.i_lct = 8'h03;
    go(s + 1);  bus.i_lct = 8'h00;
    go(s + 2);
    chk("kill.lcterr", 32'(bus.o_lcterr), 32'h1);
    go(s + 5);  bus.i_l1a = 1'b1;
    go(s + 6);  bus.i_l1a = 1'b0;
    go(s + 7);
    chk_o("kill.nomatch", 1'b1, 7'h00, 1'b1, 7'h00);
    bus.i_kill_mask = 7'h00;
    go(s + 8);  bus.i_lct = 8'h01;
    go(s + 9);  bus.i_lct = 8'h81;
    go(s + 10); bus.i_lct = 8'h80;
    chk("lcterr.alct_only", 32'(bus.o_lcterr), 32'h1);
    go(s + 11); bus.i_lct = 8'h00;
    chk("lcterr.consistent", 32'(bus.o_lcterr), 32'h0);
    go(s + 12);
    chk("lcterr.cfeb_only", 32'(bus.o_lcterr), 32'h1);

    // ---------------- P=5: back-to-back pushes -------------------------------
    bus.i_latency  = 7'd20;
    bus.i_push_dly = 5'd5;
    do_reset();
    s = cyc + 2;
    go(s);      bus.i_lct = 8'h02;
    go(s + 2);  bus.i_lct = 8'h00;
    go(s + 20); bus.i_l1a = 1'b1;
    go(s + 22); bus.i_l1a = 1'b0;
    chk_o("p5.m1", 1'b1, 7'h01, 1'b0, 7'h00);
    go(s + 23);
    chk_o("p5.m2", 1'b1, 7'h01, 1'b0, 7'h00);
    go(s + 26);
    chk("p5.push_early", 32'(bus.o_push), 32'h0);
    go(s + 27);
    chk("p5.push1", 32'(bus.o_push), 32'h01);
    go(s + 28);
    chk("p5.push2", 32'(bus.o_push), 32'h01);
    go(s + 29);
    chk("p5.push_end", 32'(bus.o_push), 32'h0);
    chk("p5.cnt", 32'(bus.o_l1a_cnt), 32'h2);

    // ---------------- reset while pushes are in flight -----------------------
    do_reset();
    s = cyc + 2;
    go(s);      bus.i_lct = 8'h02;
    go(s + 2);  bus.i_lct = 8'h00;
    go(s + 20); bus.i_l1a = 1'b1;
    go(s + 22); bus.i_l1a = 1'b0;
    go(s + 25); rst = 1'b1;
    go(s + 26); rst = 1'b0;
    chk_o("midrst", 1'b0, 7'h00, 1'b0, 7'h00);
    chk("midrst.cnt", 32'(bus.o_l1a_cnt), 32'h0);
    chk("midrst.lcterr", 32'(bus.o_lcterr), 32'h0);
    go(s + 27);
    chk("midrst.push1", 32'(bus.o_push), 32'h0);
    go(s + 28);
    chk("midrst.push2", 32'(bus.o_push), 32'h0);

    // ---------------- calibration path ---------------------------------------
    bus.i_push_dly = 5'd0;
    do_reset();
    bus.i_cal_mode = 1'b1;
    s = cyc + 2;
    for (int k = s; k <= s + 22; k++) begin
      go(k);
      bus.i_lct     = k[0] ? 8'hFE : 8'h00;
      bus.i_l1a     = k[0];
      bus.i_cal_lct = (k == s) ? 8'h10 : 8'h00;
      bus.i_cal_l1a = (k == s + 20);
      if (k == s + 10) chk_o("cal.quiet", 1'b0, 7'h00, 1'b0, 7'h00);
      if (k == s + 22) begin
        chk_o("cal.match", 1'b1, 7'h08, 1'b0, 7'h08);
        chk("cal.cnt", 32'(bus.o_l1a_cnt), 32'h1);
      end
    end
    idle_in();
    bus.i_cal_mode = 1'b1;
    go(s + 26);
    chk("cal.cnt_final", 32'(bus.o_l1a_cnt), 32'h1);
    bus.i_cal_mode = 1'b0;

    // ---------------- L1A counter wrap ---------------------------------------
    force dut.r_cnt = 24'hFFFFFF;
    nx();
    release dut.r_cnt;
    nx();
    chk("wrap.preload", 32'(bus.o_l1a_cnt), 32'h00FFFFFF);
    bus.i_l1a = 1'b1;
    nx();
    bus.i_l1a = 1'b0;
    chk("wrap.hold", 32'(bus.o_l1a_cnt), 32'h00FFFFFF);
    nx();
    chk("wrap.zero", 32'(bus.o_l1a_cnt), 32'h0);

    nx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
